// File: rtl/prog_sequencer_if.sv
// Control/status bundle between the program sequencer and its testbench/core side.
// The sequencer drives everything except Start and Ack.
interface prog_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             Start;
  logic             Ack;
  logic [1:0]       ProgState;
  logic             PCInit;
  logic [9:0]       StartAddr;
  logic             Busy;
  logic             ProgDone;
  logic             TimeoutErr;
  logic [CNT_W-1:0] CycleCount;
  logic [CNT_W-1:0] LastCycles;

  modport master (
    output Start, Ack,
    input  ProgState, PCInit, StartAddr, Busy, ProgDone, TimeoutErr, CycleCount, LastCycles
  );

  modport slave (
    input  Start, Ack,
    output ProgState, PCInit, StartAddr, Busy, ProgDone, TimeoutErr, CycleCount, LastCycles
  );
endinterface

// File: rtl/prog_sequencer.sv
// Launches benchmark programs 1/2/3 in rotation: one-cycle PC init, RUN until Ack or watchdog, then a done pulse.
// Start seen in IDLE gives PCInit on the next cycle; Start elsewhere is dropped, never queued.
module prog_sequencer #(
  parameter logic [9:0]       PROG1_ADDR = 10'd0,
  parameter logic [9:0]       PROG2_ADDR = 10'd128,
  parameter logic [9:0]       PROG3_ADDR = 10'd320,
  parameter int               CNT_W      = 16,
  parameter logic [CNT_W-1:0] MAX_CYCLES = {CNT_W{1'b1}}
) (
  input  logic            CLK,
  input  logic            Reset,
  prog_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_prog;
  logic [1:0]       r_sel;
  logic [9:0]       r_addr;
  logic             r_tmo;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_last;
  logic [9:0]       w_base;
  logic [CNT_W:0]   w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_wdog;

  // Extra bit on the increment keeps the watchdog compare exact at the counter's top value.
  assign w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
  assign w_cnt_nxt = (&r_cnt) ? r_cnt : w_cnt_inc[CNT_W-1:0];
  assign w_wdog    = (w_cnt_inc == {1'b0, MAX_CYCLES});

  always_comb begin
    w_base = PROG1_ADDR;
    case (r_sel)
      2'b10:   w_base = PROG2_ADDR;
      2'b11:   w_base = PROG3_ADDR;
      default: w_base = PROG1_ADDR;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.Start) w_next = S_LOAD;
      S_LOAD:  w_next = S_RUN;
      S_RUN:   if (bus.Ack || w_wdog) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_prog <= 2'b00;
      r_sel  <= 2'b01;
      r_addr <= PROG1_ADDR;
      r_tmo  <= 1'b0;
      r_cnt  <= '0;
      r_last <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.Start) begin
            r_prog <= r_sel;
            r_addr <= w_base;
            r_cnt  <= '0;
          end
        end
        S_RUN: begin
          r_cnt <= w_cnt_nxt;
          // Ack has priority: a program finishing on the watchdog cycle is not a timeout.
          if (bus.Ack) begin
            r_last <= w_cnt_nxt;
          end else if (w_wdog) begin
            r_tmo  <= 1'b1;
            r_last <= MAX_CYCLES;
          end
        end
        S_DONE: r_sel <= (r_sel == 2'b11) ? 2'b01 : r_sel + 2'd1;
        default: ;
      endcase
    end
  end

  assign bus.ProgState  = r_prog;
  assign bus.StartAddr  = r_addr;
  assign bus.PCInit     = (r_state == S_LOAD);
  assign bus.Busy       = (r_state == S_LOAD) || (r_state == S_RUN);
  assign bus.ProgDone   = (r_state == S_DONE);
  assign bus.TimeoutErr = r_tmo;
  assign bus.CycleCount = r_cnt;
  assign bus.LastCycles = r_last;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer with a 20-cycle watchdog: fixed vector table, corner sequences, randomized runs.
module tb_prog_sequencer;

  localparam int WDOG = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  prog_sequencer_if #(.CNT_W(16)) sif ();

  prog_sequencer #(.MAX_CYCLES(16'd20)) dut (
    .CLK  (clk),
    .Reset(rst),
    .bus  (sif)
  );

  typedef struct {
    int ack_at;
    bit hold;
    bit ack_load;
    int prog;
    int addr;
    int last;
    int tmo;
  } vec_t;

  vec_t tbl[6];
  int   addrs[3];

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    sif.Start = 1'b0;
    sif.Ack = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // One complete launch; ack_at outside 1..WDOG means the core never acks in time.
  task automatic run_prog(input int ack_at, input bit hold, input bit ack_load,
                          input int eprog, input int eaddr, input int elast, input int etmo);
    int eend;
    eend = (ack_at >= 1 && ack_at <= WDOG) ? ack_at : WDOG;
    sif.Start = 1'b1;
    step();
    chk("load_pcinit", int'(sif.PCInit), 1);
    chk("load_busy", int'(sif.Busy), 1);
    chk("load_prog", int'(sif.ProgState), eprog);
    chk("load_addr", int'(sif.StartAddr), eaddr);
    chk("load_cnt", int'(sif.CycleCount), 0);
    sif.Start = hold;
    sif.Ack = ack_load;
    step();
    for (int k = 1; k <= eend; k++) begin
      chk("run_busy", int'(sif.Busy), 1);
      chk("run_pcinit", int'(sif.PCInit), 0);
      chk("run_done", int'(sif.ProgDone), 0);
      chk("run_cnt", int'(sif.CycleCount), k - 1);
      chk("run_addr", int'(sif.StartAddr), eaddr);
      sif.Ack = (k == ack_at);
      step();
    end
    chk("done_pulse", int'(sif.ProgDone), 1);
    chk("done_busy", int'(sif.Busy), 0);
    chk("done_last", int'(sif.LastCycles), elast);
    chk("done_tmo", int'(sif.TimeoutErr), etmo);
    chk("done_cnt", int'(sif.CycleCount), eend);
    chk("done_prog", int'(sif.ProgState), eprog);
    sif.Ack = 1'b0;
    sif.Start = 1'b0;
    step();
    chk("idle_done", int'(sif.ProgDone), 0);
    chk("idle_busy", int'(sif.Busy), 0);
    chk("idle_pcinit", int'(sif.PCInit), 0);
  endtask

  initial begin
    int pc_seen;
    int n;
    int mtmo;
    sif.Start = 1'b0;
    sif.Ack = 1'b0;
    addrs[0] = 0;
    addrs[1] = 128;
    addrs[2] = 320;
    //            ack hold ackL prog addr last tmo
    tbl[0] = '{10, 1'b0, 1'b0, 1,   0,  10, 0};
    tbl[1] = '{ 3, 1'b1, 1'b0, 2, 128,   3, 0};
    tbl[2] = '{ 5, 1'b1, 1'b1, 3, 320,   5, 0};
    tbl[3] = '{20, 1'b0, 1'b0, 1,   0,  20, 0};
    tbl[4] = '{ 0, 1'b0, 1'b0, 2, 128,  20, 1};
    tbl[5] = '{ 7, 1'b0, 1'b0, 3, 320,   7, 1};

    @(negedge clk);
    do_reset();
    chk("rst_prog", int'(sif.ProgState), 0);
    chk("rst_addr", int'(sif.StartAddr), 0);
    chk("rst_pcinit", int'(sif.PCInit), 0);
    chk("rst_busy", int'(sif.Busy), 0);
    chk("rst_done", int'(sif.ProgDone), 0);
    chk("rst_tmo", int'(sif.TimeoutErr), 0);
    chk("rst_cnt", int'(sif.CycleCount), 0);
    chk("rst_last", int'(sif.LastCycles), 0);

    for (int i = 0; i < 6; i++)
      run_prog(tbl[i].ack_at, tbl[i].hold, tbl[i].ack_load,
               tbl[i].prog, tbl[i].addr, tbl[i].last, tbl[i].tmo);

    // Long idle: nothing moves, no spurious PC loads.
    pc_seen = 0;
    repeat (50) begin
      if (sif.PCInit) pc_seen++;
      step();
    end
    chk("idle_pcinit_cnt", pc_seen, 0);
    chk("idle_prog_hold", int'(sif.ProgState), 3);
    chk("idle_cnt_frozen", int'(sif.CycleCount), 7);
    chk("idle_tmo_sticky", int'(sif.TimeoutErr), 1);

    // Reset in the middle of program 2.
    do_reset();
    run_prog(2, 1'b0, 1'b0, 1, 0, 2, 0);
    sif.Start = 1'b1;
    step();
    sif.Start = 1'b0;
    repeat (5) step();
    chk("mid_busy_pre", int'(sif.Busy), 1);
    chk("mid_prog_pre", int'(sif.ProgState), 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_prog", int'(sif.ProgState), 0);
    chk("mid_busy", int'(sif.Busy), 0);
    chk("mid_cnt", int'(sif.CycleCount), 0);
    chk("mid_last", int'(sif.LastCycles), 0);
    chk("mid_addr", int'(sif.StartAddr), 0);
    run_prog(4, 1'b0, 1'b0, 1, 0, 4, 0);

    // Randomized launches against a launch-level model.
    do_reset();
    n = 0;
    mtmo = 0;
    repeat (40) begin
      int gap;
      int ack_at;
      int elast;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        sif.Ack = 1'($urandom_range(0, 1));
        chk("rnd_idle_pcinit", int'(sif.PCInit), 0);
        step();
      end
      sif.Ack = 1'b0;
      ack_at = $urandom_range(0, 24);
      if (ack_at >= 1 && ack_at <= WDOG) begin
        elast = ack_at;
      end else begin
        elast = WDOG;
        mtmo = 1;
      end
      run_prog(ack_at, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               (n % 3) + 1, addrs[n % 3], elast, mtmo);
      n++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
